// File: rtl/prog_mem.sv
// Program/data memory with a byte-serial boot loader. It holds the processor in reset
// until the image is loaded. Optional load checksum is enabled by PROG_MEM_CSUM_EN.
module prog_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   load_words,
    output logic [7:0]        load_csum
);

    typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_e;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [15:0]         rdata_q;
    logic                xfer;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem [2**ADDR_W];

    // Address bits above ADDR_W are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[15:ADDR_W];

    assign xfer = load_valid && (state_q != RUN);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hi_d      = hi_q;
        words_d   = words_q;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr[ADDR_W-1:0];
        mem_wdata = cpu_wdata;
        case (state_q)
            LOAD_HI: begin
                if (xfer) begin
                    hi_d = load_data;
                    if (load_last) begin
                        mem_we    = 1'b1;
                        mem_addr  = ptr_q;
                        mem_wdata = {load_data, 8'h00};
                        words_d   = words_q + (ADDR_W+1)'(1);
                        state_d   = RUN;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (xfer) begin
                    mem_we    = 1'b1;
                    mem_addr  = ptr_q;
                    mem_wdata = {hi_q, load_data};
                    ptr_d     = ptr_q + ADDR_W'(1);
                    words_d   = words_q + (ADDR_W+1)'(1);
                    // A full memory ends the load instead of wrapping the pointer.
                    state_d   = (load_last || ptr_q == PTR_MAX) ? RUN : LOAD_HI;
                end
            end
            RUN: begin
                mem_we = cpu_we;
            end
            default: state_d = LOAD_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_HI;
            ptr_q   <= '0;
            hi_q    <= '0;
            words_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            words_q <= words_d;
            rdata_q <= (state_q == RUN) ? mem[cpu_addr[ADDR_W-1:0]] : 16'h0000;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; the non-blocking write means a
    // same-edge read of the same address returns the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

`ifdef PROG_MEM_CSUM_EN
    logic [7:0] csum_q, csum_d;

    assign csum_d = xfer ? csum_q + load_data : csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign load_csum = csum_q;
`else
    assign load_csum = 8'h00;
`endif

    assign load_ready = (state_q != RUN);
    assign cpu_hold   = (state_q != RUN);
    assign load_done  = (state_q == RUN);
    assign load_words = words_q;
    assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: an ADDR_W=8 instance for load/run behaviour and an
// ADDR_W=2 instance for the full-memory case; reads are checked through a scoreboard queue.
module tb_prog_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, rst2;
    logic        load_valid, load_last, cpu_we;
    logic [7:0]  load_data;
    logic [15:0] cpu_addr, cpu_wdata;

    logic        ready8, hold8, done8;
    logic [15:0] rdata8;
    logic [8:0]  words8;
    logic [7:0]  csum8;
    logic        ready2, hold2, done2;
    logic [15:0] rdata2;
    logic [2:0]  words2;
    logic [7:0]  csum2;

    prog_mem #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst8), .load_valid(load_valid), .load_ready(ready8),
        .load_data(load_data), .load_last(load_last), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata8),
        .cpu_hold(hold8), .load_done(done8), .load_words(words8), .load_csum(csum8)
    );

    prog_mem #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst2), .load_valid(load_valid), .load_ready(ready2),
        .load_data(load_data), .load_last(load_last), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata2),
        .cpu_hold(hold2), .load_done(done2), .load_words(words2), .load_csum(csum2)
    );

`ifdef PROG_MEM_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sel2     = 1'b0;
    logic [15:0] model [256];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ecs(input logic [7:0] s);
        return CSUM_EN ? 32'(s) : 32'h0;
    endfunction

    task automatic send(input logic [7:0] b, input logic l);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = b;
        load_last  = l;
    endtask

    task automatic idle();
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 8'h00;
    endtask

    // Drive one processor cycle; the read issued by the previous call is checked first.
    task automatic cpu(input logic [15:0] a, input logic we, input logic [15:0] wd);
        int idx;
        logic [15:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd", 32'(sel2 ? rdata2 : rdata8), 32'(e));
        end
        cpu_addr  = a;
        cpu_we    = we;
        cpu_wdata = wd;
        idx = sel2 ? int'(a[1:0]) : int'(a[7:0]);
        exp_q.push_back(model[idx]);
        if (we) model[idx] = wd;
    endtask

    task automatic cpu_flush();
        logic [15:0] e;
        @(negedge clk);
        cpu_we = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd", 32'(sel2 ? rdata2 : rdata8), 32'(e));
        end
    endtask

    task automatic pulse_rst8();
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic rdy [10];

        rst8 = 1'b1; rst2 = 1'b1;
        load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00;
        cpu_addr = 16'h0; cpu_we = 1'b0; cpu_wdata = 16'h0;
        #12;
        check("rst_ready", 32'(ready8), 1);
        check("rst_hold", 32'(hold8), 1);
        check("rst_done", 32'(done8), 0);
        check("rst_rdata", 32'(rdata8), 0);
        check("rst_words", 32'(words8), 0);
        check("rst_csum", 32'(csum8), 0);
        check("rst2_hold", 32'(hold2), 1);
        @(negedge clk);
        rst8 = 1'b0;

        // Basic image C1 05 08 01.
        send(8'hC1, 1'b0); send(8'h05, 1'b0); send(8'h08, 1'b0); send(8'h01, 1'b1);
        check("pre_done", 32'(done8), 0);
        check("pre_hold", 32'(hold8), 1);
        idle();
        check("img1_done", 32'(done8), 1);
        check("img1_hold", 32'(hold8), 0);
        check("img1_ready", 32'(ready8), 0);
        check("img1_words", 32'(words8), 2);
        check("img1_csum", 32'(csum8), ecs(8'hCF));

        // Host bytes in RUN are ignored.
        send(8'h5A, 1'b1); idle();
        check("run_ign_words", 32'(words8), 2);
        check("run_ign_csum", 32'(csum8), ecs(8'hCF));

        model[0] = 16'hC105; model[1] = 16'h0801;
        cpu(16'h0000, 1'b0, 16'h0);
        cpu(16'h0001, 1'b0, 16'h0);
        cpu(16'h0001, 1'b1, 16'h1234);
        cpu(16'h0001, 1'b0, 16'h0);
        cpu(16'hFF01, 1'b0, 16'h0);
        cpu(16'h0000, 1'b0, 16'h0);
        cpu_flush();

        // Asynchronous reset in RUN: hold reasserts before any clock edge.
        @(negedge clk);
        #2 rst8 = 1'b1;
        #1;
        check("arst_hold", 32'(hold8), 1);
        check("arst_done", 32'(done8), 0);
        check("arst_ready", 32'(ready8), 1);
        check("arst_words", 32'(words8), 0);
        check("arst_rdata", 32'(rdata8), 0);
        @(negedge clk);
        rst8 = 1'b0;

        // Partial load then reset; processor writes during load must be ignored.
        cpu_addr = 16'h0001; cpu_we = 1'b1; cpu_wdata = 16'hDEAD;
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); idle();
        check("part_words", 32'(words8), 1);
        check("part_ready", 32'(ready8), 1);
        check("part_rdata", 32'(rdata8), 0);
        pulse_rst8();
        send(8'h44, 1'b0); send(8'h55, 1'b1);
        cpu_we = 1'b0; cpu_addr = 16'h0;
        check("reload_rdata", 32'(rdata8), 0);
        idle();
        check("reload_words", 32'(words8), 1);
        check("reload_done", 32'(done8), 1);
        check("reload_csum", 32'(csum8), ecs(8'h99));
        model[0] = 16'h4455;
        cpu(16'h0000, 1'b0, 16'h0);
        cpu(16'h0001, 1'b0, 16'h0);
        cpu_flush();

        // Odd-length image: trailing lone hi byte padded with 00.
        pulse_rst8();
        send(8'h77, 1'b0); send(8'h77, 1'b0); send(8'hAB, 1'b1); idle();
        check("odd_words", 32'(words8), 2);
        check("odd_done", 32'(done8), 1);
        check("odd_csum", 32'(csum8), ecs(8'h99));
        model[0] = 16'h7777; model[1] = 16'hAB00;
        cpu(16'h0000, 1'b0, 16'h0);
        cpu(16'h0001, 1'b0, 16'h0);
        cpu_flush();

        // Checksum wrap.
        pulse_rst8();
        send(8'hFF, 1'b0); send(8'h02, 1'b1); idle();
        check("csum_wrap", 32'(csum8), ecs(8'h01));
        check("csum_words", 32'(words8), 1);
        model[0] = 16'hFF02;
        cpu(16'h0000, 1'b0, 16'h0);
        cpu_flush();

        // Full-memory case on the 4-word instance.
        @(negedge clk);
        rst8 = 1'b1;
        sel2 = 1'b1;
        rst2 = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(i + 1), 1'b0);
            rdy[i] = ready2;
            if (ready2) acc++;
        end
        idle();
        check("full_accepted", 32'(acc), 8);
        check("full_ready_b8", 32'(rdy[7]), 1);
        check("full_ready_b9", 32'(rdy[8]), 0);
        check("full_ready_b10", 32'(rdy[9]), 0);
        check("full_words", 32'(words2), 4);
        check("full_done", 32'(done2), 1);
        check("full_csum", 32'(csum2), ecs(8'h24));
        model[0] = 16'h0102; model[1] = 16'h0304;
        model[2] = 16'h0506; model[3] = 16'h0708;
        cpu(16'h0000, 1'b0, 16'h0);
        cpu(16'h0001, 1'b0, 16'h0);
        cpu(16'h0002, 1'b0, 16'h0);
        cpu(16'h0003, 1'b0, 16'h0);
        cpu(16'h0004, 1'b0, 16'h0);
        cpu_flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
